// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: data-cache handshake, pipeline hold until dhit,
// LL/SC link register with snoop invalidation, sticky halt and stall counter.
module mem_access_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ex_valid,
  input  logic             ex_MemRead,
  input  logic             ex_MemWrite,
  input  logic             ex_ll,
  input  logic             ex_sc,
  input  logic             ex_halt,
  input  logic [31:0]      ex_addr,
  input  logic [31:0]      ex_store,
  input  logic             dhit,
  input  logic [31:0]      dmemload,
  input  logic             snoop_inv,
  input  logic [31:0]      snoop_addr,
  output logic             dREN,
  output logic             dWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic [31:0]      mem_result,
  output logic             mem_stall,
  output logic             mwb_WEN,
  output logic             mwb_flush,
  output logic             halt_out,
  output logic             link_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             link_valid_q, link_valid_d;
  logic [29:0]      link_addr_q, link_addr_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic sc_fail_s, req_s, stall_s, done_s, ll_set_s, link_clr_s, snoop_hit_s;

  assign sc_fail_s = ex_valid & ex_sc & ~(link_valid_q & (link_addr_q == ex_addr[31:2]));
  assign req_s     = ex_valid & (ex_MemRead | ex_MemWrite) & ~sc_fail_s & (state_q != HALTED);
  assign stall_s   = req_s & ~dhit;
  assign done_s    = req_s & dhit;

  assign dREN      = req_s & ex_MemRead;
  assign dWEN      = req_s & ex_MemWrite;
  assign dmemaddr  = ex_addr;
  assign dmemstore = ex_store;
  assign mem_stall = stall_s;
  assign mwb_WEN   = ~stall_s;
  assign mwb_flush = stall_s;

  assign halt_out   = halt_q;
  assign link_valid = link_valid_q;
  assign stall_cnt  = cnt_q;

  // Snoop is compared against the post-LL address so a same-cycle snoop beats the set.
  assign ll_set_s    = done_s & ex_MemRead & ex_ll;
  assign link_addr_d = ll_set_s ? ex_addr[31:2] : link_addr_q;
  assign snoop_hit_s = snoop_inv & (snoop_addr[31:2] == link_addr_d);
  assign link_clr_s  = (done_s & ex_MemWrite & ex_sc)
                     | (done_s & ex_MemWrite & (ex_addr[31:2] == link_addr_q))
                     | snoop_hit_s
                     | (ex_valid & ex_halt);
  assign link_valid_d = link_clr_s ? 1'b0 : (ll_set_s ? 1'b1 : link_valid_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ex_valid && ex_halt) begin
          state_d = HALTED;
        end else if (stall_s) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (dhit) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    halt_d = (state_d == HALTED);
    if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    mem_result = ex_addr;
    if (ex_valid && ex_MemRead) begin
      mem_result = dmemload;
    end else if (ex_valid && ex_sc) begin
      mem_result = sc_fail_s ? 32'd0 : 32'd1;
    end else begin
      mem_result = ex_addr;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      link_valid_q <= 1'b0;
      link_addr_q  <= 30'd0;
      halt_q       <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      halt_q       <= halt_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: scoreboarded load/SC results plus
// link-register, halt, stall-counter saturation and reset checks.
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid, ex_MemRead, ex_MemWrite, ex_ll, ex_sc, ex_halt;
  logic [31:0] ex_addr, ex_store, dmemload, snoop_addr;
  logic        dhit, snoop_inv;

  logic        dREN, dWEN, mem_stall, mwb_WEN, mwb_flush, halt_out, link_valid;
  logic [31:0] dmemaddr, dmemstore, mem_result;
  logic [15:0] stall_cnt;

  logic        dREN4, dWEN4, mem_stall4, mwb_WEN4, mwb_flush4, halt_out4, link_valid4;
  logic [31:0] dmemaddr4, dmemstore4, mem_result4;
  logic [3:0]  stall_cnt4;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  always #5 CLK = ~CLK;

  mem_access_ctrl #(.CNT_W(16)) u_dut (
    .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_ll(ex_ll), .ex_sc(ex_sc), .ex_halt(ex_halt),
    .ex_addr(ex_addr), .ex_store(ex_store), .dhit(dhit), .dmemload(dmemload),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr), .dREN(dREN), .dWEN(dWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_result(mem_result),
    .mem_stall(mem_stall), .mwb_WEN(mwb_WEN), .mwb_flush(mwb_flush),
    .halt_out(halt_out), .link_valid(link_valid), .stall_cnt(stall_cnt)
  );

  mem_access_ctrl #(.CNT_W(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_ll(ex_ll), .ex_sc(ex_sc), .ex_halt(ex_halt),
    .ex_addr(ex_addr), .ex_store(ex_store), .dhit(dhit), .dmemload(dmemload),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr), .dREN(dREN4), .dWEN(dWEN4),
    .dmemaddr(dmemaddr4), .dmemstore(dmemstore4), .mem_result(mem_result4),
    .mem_stall(mem_stall4), .mwb_WEN(mwb_WEN4), .mwb_flush(mwb_flush4),
    .halt_out(halt_out4), .link_valid(link_valid4), .stall_cnt(stall_cnt4)
  );

  // op: 0 idle, 1 LW, 2 SW, 3 LL, 4 SC, 5 HALT; inputs settle 1 time unit later
  task automatic drive(input int op, input logic [31:0] addr, input logic [31:0] st,
                       input logic hit, input logic [31:0] ld);
    ex_valid    = (op != 0);
    ex_MemRead  = (op == 1) || (op == 3);
    ex_MemWrite = (op == 2) || (op == 4);
    ex_ll       = (op == 3);
    ex_sc       = (op == 4);
    ex_halt     = (op == 5);
    ex_addr     = addr;
    ex_store    = st;
    dhit        = hit;
    dmemload    = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    snoop_inv = 1'b0; snoop_addr = 32'd0;
    drive(0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick(); tick();
    n_tests++; if (halt_out !== 1'b0) begin n_fail++; $display("FAIL rst_halt: got %b want 0", halt_out); end
    n_tests++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL rst_link: got %b want 0", link_valid); end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
    n_tests++; if ({dREN, dWEN, mem_stall, mwb_WEN} !== 4'b0001) begin n_fail++; $display("FAIL rst_ctl: got %b want 0001", {dREN, dWEN, mem_stall, mwb_WEN}); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_load_stall();
    exp_q.push_back(32'hDEADBEEF);
    for (int c = 0; c < 3; c++) begin
      drive(1, 32'h100, 32'd0, (c == 2), (c == 2) ? 32'hDEADBEEF : 32'h0);
      n_tests++; if (dREN !== 1'b1 || dmemaddr !== 32'h100) begin n_fail++; $display("FAIL ld_dren c%0d: got %b/%h want 1/00000100", c, dREN, dmemaddr); end
      n_tests++; if ({mem_stall, mwb_flush, mwb_WEN} !== ((c == 2) ? 3'b001 : 3'b110)) begin n_fail++; $display("FAIL ld_stall c%0d: got %b want %b", c, {mem_stall, mwb_flush, mwb_WEN}, (c == 2) ? 3'b001 : 3'b110); end
      if (mwb_WEN === 1'b1 && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_tests++; if (mem_result !== exp_v) begin n_fail++; $display("FAIL ld_result: got %h want %h", mem_result, exp_v); end
      end
      tick();
    end
    drive(0, 32'd0, 32'd0, 1'b0, 32'd0);
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ld_sb: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    n_tests++; if (stall_cnt !== 16'd2 || stall_cnt4 !== 4'd2) begin n_fail++; $display("FAIL ld_cnt: got %0d/%0d want 2/2", stall_cnt, stall_cnt4); end
    tick();
  endtask

  task automatic test_ll_sc();
    drive(3, 32'h200, 32'd0, 1'b1, 32'h0000_1234);
    exp_q.push_back(32'h0000_1234);
    exp_v = exp_q.pop_front();
    n_tests++; if (mem_result !== exp_v || mem_stall !== 1'b0) begin n_fail++; $display("FAIL ll_result: got %h/%b want %h/0", mem_result, mem_stall, exp_v); end
    tick();
    n_tests++; if (link_valid !== 1'b1) begin n_fail++; $display("FAIL ll_link: got %b want 1", link_valid); end
    drive(4, 32'h200, 32'd5, 1'b1, 32'd0);
    exp_q.push_back(32'd1);
    exp_v = exp_q.pop_front();
    n_tests++; if (dWEN !== 1'b1 || dmemstore !== 32'd5) begin n_fail++; $display("FAIL sc_dwen: got %b/%h want 1/00000005", dWEN, dmemstore); end
    n_tests++; if (mem_result !== exp_v) begin n_fail++; $display("FAIL sc_result: got %h want %h", mem_result, exp_v); end
    tick();
    n_tests++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL sc_link: got %b want 0", link_valid); end
    drive(0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
  endtask

  task automatic test_snoop();
    drive(3, 32'h200, 32'd0, 1'b1, 32'd7);
    tick();
    drive(0, 32'd0, 32'd0, 1'b0, 32'd0);
    snoop_inv = 1'b1; snoop_addr = 32'h203;
    tick();
    snoop_inv = 1'b0;
    n_tests++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL snp_link: got %b want 0", link_valid); end
    drive(4, 32'h200, 32'd9, 1'b0, 32'd0);
    exp_q.push_back(32'd0);
    exp_v = exp_q.pop_front();
    n_tests++; if ({dWEN, mem_stall, mwb_WEN} !== 3'b001) begin n_fail++; $display("FAIL snp_sc_ctl: got %b want 001", {dWEN, mem_stall, mwb_WEN}); end
    n_tests++; if (mem_result !== exp_v) begin n_fail++; $display("FAIL snp_sc_result: got %h want %h", mem_result, exp_v); end
    tick();
    // LL with same-cycle snoop to the same word: snoop wins
    drive(3, 32'h300, 32'd0, 1'b1, 32'd0);
    snoop_inv = 1'b1; snoop_addr = 32'h300;
    tick();
    snoop_inv = 1'b0;
    n_tests++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL llsnp_link: got %b want 0", link_valid); end
    drive(4, 32'h300, 32'd1, 1'b1, 32'd0);
    n_tests++; if (dWEN !== 1'b0 || mem_result !== 32'd0) begin n_fail++; $display("FAIL llsnp_sc: got %b/%h want 0/00000000", dWEN, mem_result); end
    tick();
    // Plain SW: other word keeps the link, same word (low bits ignored) clears it
    drive(3, 32'h400, 32'd0, 1'b1, 32'd0);
    tick();
    drive(2, 32'h404, 32'd3, 1'b1, 32'd0);
    tick();
    n_tests++; if (link_valid !== 1'b1) begin n_fail++; $display("FAIL sw_other: got %b want 1", link_valid); end
    drive(2, 32'h402, 32'd3, 1'b1, 32'd0);
    tick();
    n_tests++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL sw_same: got %b want 0", link_valid); end
    drive(0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
  endtask

  task automatic test_halt();
    drive(3, 32'h500, 32'd0, 1'b1, 32'd0);
    tick();
    drive(5, 32'd0, 32'd0, 1'b0, 32'd0);
    n_tests++; if (halt_out !== 1'b0) begin n_fail++; $display("FAIL halt_early: got %b want 0", halt_out); end
    tick();
    n_tests++; if (halt_out !== 1'b1 || link_valid !== 1'b0) begin n_fail++; $display("FAIL halt_set: got %b/%b want 1/0", halt_out, link_valid); end
    drive(1, 32'h100, 32'd0, 1'b0, 32'd0);
    n_tests++; if ({dREN, dWEN, mem_stall} !== 3'b000) begin n_fail++; $display("FAIL halt_lw: got %b want 000", {dREN, dWEN, mem_stall}); end
    tick(); tick();
    n_tests++; if (halt_out !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b want 1", halt_out); end
    RST = 1'b1;
    #1;
    n_tests++; if (halt_out !== 1'b0 || dREN !== 1'b1) begin n_fail++; $display("FAIL halt_rst: got %b/%b want 0/1", halt_out, dREN); end
    drive(0, 32'd0, 32'd0, 1'b0, 32'd0);
    RST = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    RST = 1'b1; #1; RST = 1'b0;
    drive(1, 32'h600, 32'd0, 1'b0, 32'd0);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 14) begin
        n_tests++; if (stall_cnt4 !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d want 15", stall_cnt4); end
      end
    end
    n_tests++; if (stall_cnt4 !== 4'd15 || stall_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_hold: got %0d/%0d want 15/20", stall_cnt4, stall_cnt); end
    n_tests++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL sat_wait: got %b want 1", mem_stall); end
    RST = 1'b1;
    drive(0, 32'd0, 32'd0, 1'b0, 32'd0);
    n_tests++; if (mem_stall !== 1'b0 || stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin n_fail++; $display("FAIL wait_rst: got %b/%0d/%0d want 0/0/0", mem_stall, stall_cnt, stall_cnt4); end
    RST = 1'b0;
    tick();
    drive(1, 32'h700, 32'd0, 1'b1, 32'hCAFE_F00D);
    n_tests++; if (dREN !== 1'b1 || mem_stall !== 1'b0 || mem_result !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL post_rst_lw: got %b/%b/%h want 1/0/cafef00d", dREN, mem_stall, mem_result); end
    tick();
    drive(0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_load_stall();
    test_ll_sc();
    test_snoop();
    test_halt();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage access controller between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Drives the data-cache request interface (dREN/dWEN) and holds the pipeline until dhit.
- Implements the LL/SC link register with snoop invalidation.
- Produces the load/SC result and the MEM/WB write-enable, plus a saturating stall-cycle counter.

Parameters:
CNT_W, 16, width of the stall-cycle performance counter (saturating)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
ex_valid  input  1  EX/MEM register holds a live instruction
ex_MemRead  input  1  load (LW or LL)
ex_MemWrite  input  1  store (SW or SC)
ex_ll  input  1  instruction is LL (with ex_MemRead)
ex_sc  input  1  instruction is SC (with ex_MemWrite)
ex_halt  input  1  instruction is HALT
ex_addr  input  32  effective address (ALU output)
ex_store  input  32  store data
dhit  input  1  cache completes current request this cycle
dmemload  input  32  cache read data, valid when dhit
snoop_inv  input  1  coherence invalidate strobe
snoop_addr  input  32  invalidated address
dREN  output  1  cache read request
dWEN  output  1  cache write request
dmemaddr  output  32  cache address
dmemstore  output  32  cache write data
mem_result  output  32  data for MEM/WB (load data or SC result 0/1)
mem_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
mwb_WEN  output  1  MEM/WB write enable
mwb_flush  output  1  MEM/WB bubble insert
halt_out  output  1  sticky halt to system
link_valid  output  1  LL reservation active
stall_cnt  output  CNT_W  total MEM stall cycles, saturating

Behaviour:
- State machine: IDLE, WAIT, HALTED.
- Access condition: req = ex_valid & (ex_MemRead | ex_MemWrite) & !sc_fail & state != HALTED.
- SC fail condition: sc_fail = ex_valid & ex_sc & !(link_valid & link_addr[31:2] == ex_addr[31:2]).
- Cache outputs (combinational):
  - dREN = req & ex_MemRead.
  - dWEN = req & ex_MemWrite.
  - dmemaddr = ex_addr; dmemstore = ex_store.
  - Requests stay asserted and stable until dhit.
- IDLE:
  - req & dhit → access completes with zero stall, stay IDLE.
  - req & !dhit → WAIT.
  - ex_valid & ex_halt → HALTED.
- WAIT: stay until dhit, then go to IDLE. EX/MEM inputs are frozen by mem_stall, so they are unchanged while in WAIT.
- HALTED: absorbing until RST. halt_out = 1 (registered, asserted the cycle after HALT is seen). dREN = dWEN = 0.
- Stall and MEM/WB control:
  - mem_stall = req & !dhit (combinational).
  - mwb_WEN = !mem_stall.
  - mwb_flush = mem_stall. A stall inserts a bubble into MEM/WB so WB does not repeat the instruction.
- mem_result (combinational):
  - load: dmemload.
  - successful SC: 32'd1.
  - failed SC: 32'd0.
  - otherwise: ex_addr.
- SC fail: no cache request, no stall, completes in the same cycle, result 0.
- Link register update (link_valid, link_addr[31:2]), evaluated in this order each clock; a later rule overrides an earlier one:
  1. LL completing (dhit) sets link_valid=1 and link_addr=ex_addr[31:2].
  2. Successful SC completing clears link_valid.
  3. Any SW/SC write completing (dhit) whose address matches link_addr clears link_valid.
  4. snoop_inv with a matching snoop_addr[31:2] clears link_valid. Snoop wins over a same-cycle LL set.
  5. HALT clears link_valid.
- stall_cnt: +1 on every cycle with mem_stall=1; saturates at all-ones; never wraps.
- Reset values: state=IDLE, link_valid=0, link_addr=0, halt_out=0, stall_cnt=0.
- Reset mid-WAIT: return to IDLE immediately. Combinational outputs follow, so the request drops if ex_valid is reset upstream.
- The word-aligned compare ignores addr[1:0].

Test Plan:
- LW addr 0x100, dhit after 3 cycles, dmemload=0xDEADBEEF → dREN high 3 cycles, mem_stall=1 and mwb_flush=1 for 2 cycles, mwb_WEN=1 on the dhit cycle with mem_result=0xDEADBEEF, stall_cnt=2.
- LL 0x200 (dhit immediate), then SC 0x200 data 5 → dWEN=1, mem_result=1, link_valid 1→0.
- LL 0x200, snoop_inv 0x203, then SC 0x200 → no dWEN, mem_result=0, mem_stall=0.
- LL 0x300 with snoop_inv 0x300 in the same dhit cycle → link_valid stays 0; following SC 0x300 fails.
- HALT in IDLE → halt_out=1 next cycle, sticky. A later LW produces no dREN. RST high → halt_out=0, state IDLE.
- Force CNT_W=4 with 20 stall cycles → stall_cnt=15 and holds; RST asserted during WAIT → mem_stall drops once ex_valid=0, stall_cnt=0.
